// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline widths and bubble constants
package pipeline_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CTRL_W = 8;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;
endpackage

// File: rtl/bypass_mux.sv
// bypass_mux: forwards writeback data onto a read port, never for register 0
module bypass_mux
  import pipeline_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] data
);
  assign data = (we && waddr != AW'(REG_ZERO) && waddr == raddr) ? wdata : rdata;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with writeback bypass, stall/flush and stall counter
module id_ex_stage #(
  parameter int DATA_W = pipeline_pkg::DATA_W,
  parameter int ADDR_W = pipeline_pkg::ADDR_W,
  parameter int CTRL_W = pipeline_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] rdata_A,
  input  logic [DATA_W-1:0] rdata_B,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_A,
  output logic [DATA_W-1:0] ex_B,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic [ADDR_W-1:0] ex_rs,
  output logic [ADDR_W-1:0] ex_rt,
  output logic [ADDR_W-1:0] ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);
  import pipeline_pkg::*;
  logic [DATA_W-1:0] ld_a, ld_b, hd_a, hd_b;
  bypass_mux #(.DW(DATA_W), .AW(ADDR_W)) u_ld_a (.we(wb_we), .waddr(wb_addr), .wdata(wb_data), .raddr(in_rs), .rdata(rdata_A), .data(ld_a));
  bypass_mux #(.DW(DATA_W), .AW(ADDR_W)) u_ld_b (.we(wb_we), .waddr(wb_addr), .wdata(wb_data), .raddr(in_rt), .rdata(rdata_B), .data(ld_b));
  bypass_mux #(.DW(DATA_W), .AW(ADDR_W)) u_hd_a (.we(wb_we), .waddr(wb_addr), .wdata(wb_data), .raddr(ex_rs), .rdata(ex_A), .data(hd_a));
  bypass_mux #(.DW(DATA_W), .AW(ADDR_W)) u_hd_b (.we(wb_we), .waddr(wb_addr), .wdata(wb_data), .raddr(ex_rt), .rdata(ex_B), .data(hd_b));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_A      <= '0;
      ex_B      <= '0;
      ex_imm    <= '0;
      ex_pc     <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      ex_ctrl   <= '0;
      stall_cnt <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_A     <= '0;
      ex_B     <= '0;
      ex_imm   <= '0;
      ex_pc    <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
      ex_ctrl  <= CTRL_W'(CTRL_NOP);
    end else if (stall) begin
      ex_A <= hd_a;
      ex_B <= hd_b;
      if (ex_valid && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end else begin
      ex_valid <= in_valid;
      ex_A     <= ld_a;
      ex_B     <= ld_b;
      ex_imm   <= in_imm;
      ex_pc    <= in_pc;
      ex_rs    <= in_rs;
      ex_rt    <= in_rt;
      ex_rd    <= in_valid ? in_rd : ADDR_W'(REG_ZERO);
      ex_ctrl  <= in_valid ? in_ctrl : CTRL_W'(CTRL_NOP);
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a register-file reference model
module tb_id_ex_stage;
  localparam int DW = 32, AW = 5, CW = 8, NW = 4;
  logic clk = 1'b0, rst, stall, flush, in_valid, wb_we;
  logic [AW-1:0] in_rs, in_rt, in_rd, wb_addr;
  logic [DW-1:0] rdata_A, rdata_B, in_imm, in_pc, wb_data;
  logic [CW-1:0] in_ctrl;
  logic ex_valid;
  logic [DW-1:0] ex_A, ex_B, ex_imm, ex_pc;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [CW-1:0] ex_ctrl;
  logic [NW-1:0] stall_cnt;
  id_ex_stage #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .rdata_A(rdata_A), .rdata_B(rdata_B),
    .in_imm(in_imm), .in_pc(in_pc), .in_ctrl(in_ctrl), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B), .ex_imm(ex_imm),
    .ex_pc(ex_pc), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .stall_cnt(stall_cnt));
  always #5 clk = ~clk;
  int checks = 0, passed = 0;
  bit rand_phase = 0;
  logic [DW-1:0] mem [32];
  logic m_valid;
  logic [DW-1:0] m_imm, m_pc;
  logic [AW-1:0] m_rs, m_rt, m_rd;
  logic [CW-1:0] m_ctrl;
  int m_cnt;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic model_zero();
    m_valid = 0; m_imm = 0; m_pc = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_ctrl = 0;
  endtask
  task automatic model_edge();
    if (rst) begin
      model_zero();
      m_cnt = 0;
    end else if (flush) model_zero();
    else if (stall) begin
      if (m_valid) m_cnt = (m_cnt + 1 > 2**NW - 1) ? 2**NW - 1 : m_cnt + 1;
    end else begin
      m_valid = in_valid; m_imm = in_imm; m_pc = in_pc; m_rs = in_rs; m_rt = in_rt;
      m_rd = in_valid ? in_rd : 0;
      m_ctrl = in_valid ? in_ctrl : 0;
    end
    if (wb_we && wb_addr != 0) mem[wb_addr] = wb_data;
  endtask
  task automatic check_model();
    chk("valid", 32'(ex_valid), 32'(m_valid));
    chk("imm", ex_imm, m_imm);
    chk("pc", ex_pc, m_pc);
    chk("rs", 32'(ex_rs), 32'(m_rs));
    chk("rt", 32'(ex_rt), 32'(m_rt));
    chk("rd", 32'(ex_rd), 32'(m_rd));
    chk("ctrl", 32'(ex_ctrl), 32'(m_ctrl));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    if (rand_phase) begin
      chk("opA_regfile", ex_A, mem[m_rs]);
      chk("opB_regfile", ex_B, mem[m_rt]);
    end
  endtask
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask
  task automatic drive(input logic v, input logic [AW-1:0] rs, rt, rd, input logic [DW-1:0] a, b,
                       input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    in_valid = v; in_rs = rs; in_rt = rt; in_rd = rd; rdata_A = a; rdata_B = b;
    wb_we = we; wb_addr = wa; wb_data = wd;
    in_imm = $urandom; in_pc = $urandom; in_ctrl = CW'($urandom);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 0;
    rst = 1; stall = 0; flush = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_zero(); m_cnt = 0;
    tick();
    rst = 0;
    chk("reset_A", ex_A, 0);
    chk("reset_B", ex_B, 0);
    drive(1, 5, 6, 9, 32'hA5A5A5A5, 32'h55AA55AA, 0, 0, 0);
    tick();
    chk("load_A", ex_A, 32'hA5A5A5A5);
    chk("load_B", ex_B, 32'h55AA55AA);
    drive(1, 5, 6, 9, 32'hA5A5A5A5, 32'h55AA55AA, 1, 5, 32'h12345678);
    tick();
    chk("bypass_A", ex_A, 32'h12345678);
    chk("bypass_B_untouched", ex_B, 32'h55AA55AA);
    drive(1, 0, 6, 9, 0, 32'h55AA55AA, 1, 0, 32'hAAAA5555);
    tick();
    chk("bypass_r0_A", ex_A, 0);
    drive(1, 3, 6, 7, 32'h33333333, 32'h11111111, 0, 0, 0);
    tick();
    stall = 1;
    drive(0, 1, 2, 3, 32'hFFFFFFFF, 32'hEEEEEEEE, 0, 0, 0);
    tick();
    wb_we = 1; wb_addr = 6; wb_data = 32'hDEADBEEF;
    tick();
    chk("refresh_B", ex_B, 32'hDEADBEEF);
    chk("refresh_A_held", ex_A, 32'h33333333);
    wb_we = 0;
    tick();
    stall = 0;
    chk("stall_cnt_3", 32'(stall_cnt), 3);
    chk("held_B", ex_B, 32'hDEADBEEF);
    stall = 1; flush = 1;
    tick();
    stall = 0; flush = 0;
    chk("flush_A", ex_A, 0);
    chk("flush_cnt_kept", 32'(stall_cnt), 3);
    drive(1, 4, 8, 12, 32'h0BADF00D, 32'hC0FFEE00, 0, 0, 0);
    tick();
    @(negedge clk);
    rst = 1;
    #1;
    model_zero(); m_cnt = 0;
    check_model();
    chk("async_rst_A", ex_A, 0);
    chk("async_rst_B", ex_B, 0);
    #1 rst = 0;
    drive(1, 4, 8, 12, 32'h0BADF00D, 32'hC0FFEE00, 0, 0, 0);
    tick();
    stall = 1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt", 32'(stall_cnt), 15);
    stall = 0;
    rst = 1;
    tick();
    rst = 0;
    rand_phase = 1;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 8);
      stall = ($urandom_range(0, 99) < 35);
      in_valid = $urandom_range(0, 1);
      in_rs = AW'($urandom); in_rt = AW'($urandom); in_rd = AW'($urandom);
      rdata_A = mem[in_rs]; rdata_B = mem[in_rt];
      in_imm = $urandom; in_pc = $urandom; in_ctrl = CW'($urandom);
      wb_we = $urandom_range(0, 1);
      wb_addr = ($urandom_range(0, 3) == 0) ? in_rs : AW'($urandom);
      wb_data = $urandom;
      tick();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
